// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port memory between the
// instruction-fetch (IF) and load/store (LS) requesters of the multi-cycle CPU.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;

    // State, counter, request latch and round-robin history
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= OWN_IF;
            last_q  <= OWN_LS;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state and strobe decode; grants are combinational in IDLE
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        if_rdata  = '0;
        ls_rdata  = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the requester not served last wins
                if (if_req && (!ls_req || (last_q == OWN_LS))) begin
                    if_gnt  = 1'b1;
                    owner_d = OWN_IF;
                    last_d  = OWN_IF;
                    we_d    = 1'b0;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    state_d = ISSUE;
                end else if (ls_req) begin
                    ls_gnt  = 1'b1;
                    owner_d = OWN_LS;
                    last_d  = OWN_LS;
                    we_d    = ls_we;
                    addr_d  = ls_addr;
                    wdata_d = ls_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_en = 1'b1;
                mem_we = we_q;
                if (MEM_LAT == 1) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = CNT_W'(MEM_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (owner_q == OWN_IF) begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                end else begin
                    ls_rvalid = 1'b1;
                    ls_rdata  = mem_rdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: instance A with MEM_LAT=2, instance B with MEM_LAT=1,
// each backed by a small behavioural memory.
module tb_mem_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // Instance A (MEM_LAT=2)
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    // Instance B (MEM_LAT=1)
    logic        b_if_req, b_if_gnt, b_if_rvalid;
    logic [31:0] b_if_addr, b_if_rdata;
    logic        b_ls_gnt, b_ls_rvalid;
    logic [31:0] b_ls_rdata;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_a (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_b (
        .clk(clk), .rstn(rstn),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .ls_req(1'b0), .ls_we(1'b0), .ls_addr(32'h0), .ls_wdata(32'h0),
        .ls_gnt(b_ls_gnt), .ls_rvalid(b_ls_rvalid), .ls_rdata(b_ls_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Behavioural memories: 0x100 holds DEADBEEF, the last write is remembered,
    // everything else reads as addr ^ A5A5A5A5
    logic [31:0] a_raddr = 32'h0;
    logic [31:0] b_raddr = 32'h0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_addr = 32'h0;
    logic [31:0] wr_data = 32'h0;

    always @(posedge clk) begin
        if (mem_en) begin
            a_raddr <= mem_addr;
            if (mem_we) begin
                wr_valid <= 1'b1;
                wr_addr  <= mem_addr;
                wr_data  <= mem_wdata;
            end
        end
        if (b_mem_en) b_raddr <= b_mem_addr;
    end

    assign mem_rdata = (a_raddr == 32'h100) ? 32'hDEADBEEF :
                       (wr_valid && a_raddr == wr_addr) ? wr_data :
                       (a_raddr ^ 32'hA5A5A5A5);
    assign b_mem_rdata = b_raddr ^ 32'hA5A5A5A5;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] if_q[$];
    exp_t        ls_q[$];
    logic [31:0] b_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a_zero(input string tag);
        chk1({tag, "_if_gnt"}, if_gnt, 1'b0);
        chk1({tag, "_ls_gnt"}, ls_gnt, 1'b0);
        chk1({tag, "_if_rvalid"}, if_rvalid, 1'b0);
        chk1({tag, "_ls_rvalid"}, ls_rvalid, 1'b0);
        chk1({tag, "_mem_en"}, mem_en, 1'b0);
        chk1({tag, "_mem_we"}, mem_we, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_if_rdata"}, if_rdata, 32'h0);
        chk({tag, "_ls_rdata"}, ls_rdata, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    // Monitor for instance A: pops expected responses and checks invariants
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rstn) begin
            chk1("a_gnt_while_busy", (if_gnt | ls_gnt) & busy, 1'b0);
            chk1("a_we_without_en", mem_we & ~mem_en, 1'b0);
            chk1("a_dual_rvalid", if_rvalid & ls_rvalid, 1'b0);
            if (if_rvalid) begin
                if (if_q.size() == 0) fail_now("a_if_rvalid_unexpected");
                else chk("a_if_rdata", if_rdata, if_q.pop_front());
            end else begin
                chk("a_if_rdata_idle", if_rdata, 32'h0);
            end
            if (ls_rvalid) begin
                if (ls_q.size() == 0) fail_now("a_ls_rvalid_unexpected");
                else begin
                    e = ls_q.pop_front();
                    if (!e.we) chk("a_ls_rdata", ls_rdata, e.data);
                end
            end else begin
                chk("a_ls_rdata_idle", ls_rdata, 32'h0);
            end
        end
    end

    // Monitor for instance B
    always @(negedge clk) begin : mon_b
        if (rstn) begin
            chk1("b_gnt_while_busy", b_if_gnt & b_busy, 1'b0);
            chk1("b_ls_rvalid", b_ls_rvalid, 1'b0);
            if (b_if_rvalid) begin
                if (b_q.size() == 0) fail_now("b_if_rvalid_unexpected");
                else chk("b_if_rdata", b_if_rdata, b_q.pop_front());
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t e;
        logic exp_if;
        rstn = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0;
        b_if_req = 1'b0; b_if_addr = 32'h0;

        // Reset values
        @(negedge clk);
        chk_a_zero("reset");
        chk1("reset_b_busy", b_busy, 1'b0);
        next_cyc();
        rstn = 1'b1;

        // Single IF read of 0x100
        next_cyc(); if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        chk1("t1_if_gnt", if_gnt, 1'b1); chk1("t1_ls_gnt", ls_gnt, 1'b0); chk1("t1_busy_T", busy, 1'b0);
        if_q.push_back(32'hDEADBEEF);
        next_cyc(); if_req = 1'b0;
        @(negedge clk);
        chk1("t1_mem_en", mem_en, 1'b1); chk1("t1_mem_we", mem_we, 1'b0);
        chk("t1_mem_addr", mem_addr, 32'h100); chk1("t1_busy_T1", busy, 1'b1);
        next_cyc(); @(negedge clk);
        chk1("t1_mem_en_once", mem_en, 1'b0); chk1("t1_busy_T2", busy, 1'b1);
        next_cyc(); @(negedge clk);
        chk1("t1_if_rvalid_T3", if_rvalid, 1'b1); chk1("t1_busy_T3", busy, 1'b1);
        next_cyc(); @(negedge clk);
        chk1("t1_busy_T4", busy, 1'b0); chk1("t1_if_rvalid_T4", if_rvalid, 1'b0);

        // LS write, then IF read back through the memory
        next_cyc(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h20; ls_wdata = 32'h12345678;
        @(negedge clk);
        chk1("t3_ls_gnt", ls_gnt, 1'b1); chk1("t3_if_gnt", if_gnt, 1'b0);
        e.we = 1'b1; e.data = 32'h0; ls_q.push_back(e);
        next_cyc(); ls_req = 1'b0; ls_we = 1'b0;
        @(negedge clk);
        chk1("t3_mem_en", mem_en, 1'b1); chk1("t3_mem_we", mem_we, 1'b1);
        chk("t3_mem_addr", mem_addr, 32'h20); chk("t3_mem_wdata", mem_wdata, 32'h12345678);
        next_cyc(); @(negedge clk);
        chk1("t3_mem_we_drop", mem_we, 1'b0);
        next_cyc(); @(negedge clk);
        chk1("t3_ls_rvalid", ls_rvalid, 1'b1); chk1("t3_no_if_rvalid", if_rvalid, 1'b0);
        next_cyc(); if_req = 1'b1; if_addr = 32'h20;
        @(negedge clk);
        chk1("t3_rd_if_gnt", if_gnt, 1'b1);
        if_q.push_back(32'h12345678);
        next_cyc(); if_req = 1'b0;
        repeat (4) next_cyc();

        // Round-robin with both requesters held for 8 accesses
        rstn = 1'b0;
        next_cyc(); next_cyc(); rstn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            next_cyc();
            if (k == 0) begin
                if_req = 1'b1; if_addr = 32'h200;
                ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300;
            end
            @(negedge clk);
            exp_if = ((k % 2) == 0);
            chk1("rr_if_gnt", if_gnt, exp_if);
            chk1("rr_ls_gnt", ls_gnt, ~exp_if);
            if (exp_if) if_q.push_back(32'hA5A5A7A5);
            else begin e.we = 1'b0; e.data = 32'hA5A5A6A5; ls_q.push_back(e); end
            for (int j = 1; j < 4; j++) begin
                next_cyc(); @(negedge clk);
                chk1("rr_gap_no_gnt", if_gnt | ls_gnt, 1'b0);
            end
        end
        next_cyc(); if_req = 1'b0; ls_req = 1'b0;
        repeat (4) next_cyc();

        // Reset in the WAIT state of an LS read
        next_cyc(); ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300;
        @(negedge clk);
        chk1("t5_ls_gnt", ls_gnt, 1'b1);
        next_cyc(); ls_req = 1'b0;
        next_cyc(); rstn = 1'b0; #1;
        chk_a_zero("t5_midreset");
        next_cyc(); next_cyc(); rstn = 1'b1;
        repeat (6) next_cyc();
        if_req = 1'b1; if_addr = 32'h200; ls_req = 1'b1; ls_addr = 32'h300;
        @(negedge clk);
        chk1("t5_tie_if_gnt", if_gnt, 1'b1); chk1("t5_tie_ls_gnt", ls_gnt, 1'b0);
        if_q.push_back(32'hA5A5A7A5);
        next_cyc(); if_req = 1'b0; ls_req = 1'b0;
        repeat (4) next_cyc();

        // MEM_LAT=1 instance: back-to-back IF reads
        b_if_req = 1'b1; b_if_addr = 32'h40;
        @(negedge clk);
        chk1("t6_gnt_T", b_if_gnt, 1'b1);
        b_q.push_back(32'hA5A5A5E5);
        next_cyc(); @(negedge clk);
        chk1("t6_mem_en_T1", b_mem_en, 1'b1); chk("t6_mem_addr", b_mem_addr, 32'h40);
        chk1("t6_gnt_T1", b_if_gnt, 1'b0);
        next_cyc(); @(negedge clk);
        chk1("t6_rvalid_T2", b_if_rvalid, 1'b1); chk1("t6_gnt_T2", b_if_gnt, 1'b0);
        chk1("t6_mem_en_T2", b_mem_en, 1'b0);
        next_cyc(); @(negedge clk);
        chk1("t6_gnt_T3", b_if_gnt, 1'b1);
        b_q.push_back(32'hA5A5A5E5);
        next_cyc(); b_if_req = 1'b0;
        repeat (4) next_cyc();

        // Every expected response must have been delivered
        @(negedge clk);
        chk("if_q_drained", 32'(if_q.size()), 32'h0);
        chk("ls_q_drained", 32'(ls_q.size()), 32'h0);
        chk("b_q_drained", 32'(b_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer for the single unified memory port of the multi-cycle CPU. It shares one single-port memory between two requesters: the instruction-fetch stage (IF) and the load/store stage (LS, used by LD/ST). It grants one access at a time using round-robin priority, drives the memory strobes for exactly one cycle, and returns read data or a write acknowledge to the granted requester after a fixed memory latency.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..15

Ports:
- clk  in  1  system clock; all state updates on posedge
- rstn  in  1  reset: one clock; reset is asynchronous and active-low
- if_req  in  1  IF access request (read only)
- if_addr  in  ADDR_W  IF address, valid while if_req=1
- if_gnt  out  1  IF request accepted this cycle
- if_rvalid  out  1  IF read data valid (one-cycle pulse)
- if_rdata  out  DATA_W  IF read data
- ls_req  in  1  LS access request
- ls_we  in  1  1=write, 0=read; valid while ls_req=1
- ls_addr  in  ADDR_W  LS address
- ls_wdata  in  DATA_W  LS write data
- ls_gnt  out  1  LS request accepted this cycle
- ls_rvalid  out  1  LS read data valid, or write done (one-cycle pulse)
- ls_rdata  out  DATA_W  LS read data
- mem_en  out  1  memory access strobe (one cycle per access)
- mem_we  out  1  memory write enable; asserted only together with mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  1 whenever state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester that was not granted last. The last-owner register resets to LS, so IF wins the first tie.
  - A grant asserts the owner's gnt combinationally in that cycle. On the same edge, owner, addr, we (0 for IF) and wdata are latched, last-owner is updated, and the FSM moves to ISSUE.
- ISSUE: mem_en=1, mem_we=latched we, mem_addr/mem_wdata driven from the latched values.
  - If MEM_LAT=1, next state is RESP.
  - Otherwise load a counter with MEM_LAT-1 and go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 1, go to RESP. WAIT lasts MEM_LAT-1 cycles.
- RESP: the owner's rvalid=1 and its rdata=mem_rdata, passed through combinationally. For writes, rvalid is the completion ack and rdata is don't-care. Next state is always IDLE.
- gnt, rvalid and mem_en are never asserted outside their states.
- Outputs in other states:
  - Non-owner rdata and all rdata outside RESP are driven 0.
  - mem_addr/mem_wdata hold their latched values until the next grant.
- Requester protocol:
  - Hold req and its fields stable until gnt. A req dropped before gnt is not served.
  - A req still high after gnt is treated as a new request once the FSM is back in IDLE.
  - A req arriving while busy waits; no gnt is issued while busy.
- Reset (any state, including mid-access): asynchronous return to IDLE.
  - The in-flight access is discarded and no rvalid is ever issued for it.
  - mem_en/mem_we drop immediately.
  - last-owner is set to LS and the counter to 0.

## Timing
- Reset values: if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_rdata, ls_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy all 0.
- Grant in cycle T → mem_en in T+1 → rvalid in T+1+MEM_LAT → IDLE in T+2+MEM_LAT.
- The earliest next grant is T+2+MEM_LAT. Throughput is one access per MEM_LAT+2 cycles.
- gnt is combinational from req/state/last-owner, with no cycle of latency in IDLE.
- All state, counter, latch and last-owner updates are registered.
- Counter width is 4 bits, sufficient for MEM_LAT ≤ 15.

## Test plan
- MEM_LAT=2, if_req=1 with if_addr=0x100 at T, memory returns 0xDEADBEEF → if_gnt at T; mem_en=1, mem_we=0, mem_addr=0x100 at T+1; if_rvalid=1 with if_rdata=0xDEADBEEF at T+3; busy high T+1..T+3.
- After reset, if_req and ls_req both high at T → if_gnt at T, ls_gnt=0. Both still high at T+4 → ls_gnt at T+4.
- ls_req=1, ls_we=1, ls_addr=0x20, ls_wdata=0x12345678 → one mem_en cycle with mem_we=1, addr 0x20, wdata 0x12345678; ls_rvalid pulse 2 cycles later; if_rvalid never asserted.
- Both reqs held high for 8 accesses → grants alternate IF, LS, IF, LS…; each gnt is exactly MEM_LAT+2=4 cycles apart; no gnt while busy=1.
- Reset asserted during WAIT of an LS read → all outputs 0 immediately, no rvalid after release. The first tie after release goes to IF.
- MEM_LAT=1, single IF read → mem_en at T+1, if_rvalid at T+2, next grant earliest at T+3.
